// File: rtl/terrain_band_renderer_if.sv
// terrain_band_renderer_if: colour types shared by the overlay renderers, plus the pixel bus
// between the VGA timing path (master) and the terrain band renderer (slave).
package color_pkg;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    localparam rgb_t BLACK       = '{8'h00, 8'h00, 8'h00};
    localparam rgb_t DIRT_DARK   = '{8'h3b, 8'h26, 8'h14};
    localparam rgb_t DIRT_MID    = '{8'h5c, 8'h3a, 8'h1e};
    localparam rgb_t DIRT_LIGHT  = '{8'h8b, 8'h5a, 8'h2b};
    localparam rgb_t DIRT_GRAY   = '{8'h6e, 8'h66, 8'h60};
    localparam rgb_t GRASS_LIGHT = '{8'h4c, 8'haf, 8'h50};
    localparam rgb_t GRASS_DARK  = '{8'h2e, 8'h7d, 8'h32};
endpackage

interface terrain_band_renderer_if;
    import color_pkg::*;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_valid;
    logic       frame_start;
    logic       scroll_en;
    rgb_t       color;
    logic       enable;
    logic       out_valid;
    modport master (
        output x, y, pix_valid, frame_start, scroll_en,
        input  color, enable, out_valid
    );
    modport slave (
        input  x, y, pix_valid, frame_start, scroll_en,
        output color, enable, out_valid
    );
endinterface

// File: rtl/terrain_band_renderer.sv
// terrain_band_renderer: 2-stage pipelined, horizontally scrolling 4-shade dirt band overlay.
// Define TERRAIN_GRASS_TOP_EN to cap the band's first cell row with a two-tone grass strip.
module terrain_band_renderer
    import color_pkg::*;
#(
    parameter int Y_TOP       = 150,
    parameter int BAND_H      = 30,
    parameter int CELL_SHIFT  = 1,
    parameter int SCROLL_STEP = 1,
    parameter int FRAME_DIV   = 2,
    parameter int H_ACTIVE    = 640
) (
    input  logic                    clk,
    input  logic                    reset,
    terrain_band_renderer_if.slave  bus
);
    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  COUNT    = 1'b1;
    localparam logic [10:0] W_Y_LO   = 11'(Y_TOP);
    localparam logic [10:0] W_Y_HI   = 11'(Y_TOP + BAND_H);
    localparam logic [10:0] W_H      = 11'(H_ACTIVE);
    localparam logic [10:0] W_STEP   = 11'(SCROLL_STEP);
    localparam logic [7:0]  W_DIV_M1 = 8'(FRAME_DIV - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_frame_cnt;
    logic [9:0]  r_scroll_off;
    logic        r1_valid;
    logic        r1_in_band;
    logic [9:0]  r1_sx;
    logic [9:0]  r1_ry;
    logic        r_out_valid;
    logic        r_enable;
    rgb_t        r_color;

    logic        w_tick;
    logic        w_wrap;
    logic [10:0] w_off_sum;
    logic [9:0]  w_off_next;
    logic [10:0] w_sx_sum;
    logic [9:0]  w_sx;
    logic        w_in_band;
    logic [1:0]  w_cx;
    logic [1:0]  w_cy;
    logic [1:0]  w_shade;
    rgb_t        w_dirt;
    rgb_t        w_px;

    // IDLE means frame_cnt sits at 0; COUNT means part way through a scroll period
    always_comb begin
        w_tick     = bus.frame_start && bus.scroll_en;
        w_wrap     = w_tick && (r_state == IDLE ? W_DIV_M1 == 8'd0 : r_frame_cnt == W_DIV_M1);
        w_off_sum  = {1'b0, r_scroll_off} + W_STEP;
        w_off_next = w_off_sum >= W_H ? 10'(w_off_sum - W_H) : w_off_sum[9:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_frame_cnt  <= '0;
            r_scroll_off <= '0;
        end else begin
            r_state      <= w_wrap ? IDLE : (w_tick ? COUNT : r_state);
            r_frame_cnt  <= w_wrap ? 8'd0 : (w_tick ? r_frame_cnt + 8'd1 : r_frame_cnt);
            r_scroll_off <= w_wrap ? w_off_next : r_scroll_off;
        end
    end

    // x may exceed the active width, but x+offset stays below 2*H_ACTIVE so one subtract wraps it
    always_comb begin
        w_in_band = bus.pix_valid && ({1'b0, bus.y} >= W_Y_LO) && ({1'b0, bus.y} < W_Y_HI);
        w_sx_sum  = {1'b0, bus.x} + {1'b0, r_scroll_off};
        w_sx      = w_sx_sum >= W_H ? 10'(w_sx_sum - W_H) : w_sx_sum[9:0];
    end

    always_comb begin
        w_cx    = 2'(r1_sx >> CELL_SHIFT);
        w_cy    = 2'(r1_ry >> CELL_SHIFT);
        w_shade = w_cx + w_cy;
        w_dirt  = w_shade == 2'd0 ? DIRT_DARK :
                  w_shade == 2'd1 ? DIRT_MID  :
                  w_shade == 2'd2 ? DIRT_LIGHT : DIRT_GRAY;
`ifdef TERRAIN_GRASS_TOP_EN
        w_px    = (r1_ry >> CELL_SHIFT) == 10'd0 ? (w_cx[0] ? GRASS_DARK : GRASS_LIGHT) : w_dirt;
`else
        w_px    = w_dirt;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid    <= 1'b0;
            r1_in_band  <= 1'b0;
            r1_sx       <= '0;
            r1_ry       <= '0;
            r_out_valid <= 1'b0;
            r_enable    <= 1'b0;
            r_color     <= BLACK;
        end else begin
            r1_valid    <= bus.pix_valid;
            r1_in_band  <= w_in_band;
            r1_sx       <= w_sx;
            r1_ry       <= bus.y - W_Y_LO[9:0];
            r_out_valid <= r1_valid;
            r_enable    <= r1_in_band;
            r_color     <= r1_in_band ? w_px : BLACK;
        end
    end

    assign bus.color     = r_color;
    assign bus.enable    = r_enable;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_terrain_band_renderer.sv
// tb_terrain_band_renderer: three renderers (default, step 600/div 1, step 1/div 1) driven with
// shared pixels and per-instance scroll controls, checked by vector table, sequences and a model.
`timescale 1ns/1ps
module tb_terrain_band_renderer;
    import color_pkg::*;

    typedef struct packed {
        logic ov;
        logic en;
        rgb_t col;
    } out_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       pv;
        out_t       exp;
    } vec_t;

`ifdef TERRAIN_GRASS_TOP_EN
    localparam rgb_t C0 = GRASS_LIGHT, C1 = GRASS_DARK, C2 = GRASS_LIGHT, C3 = GRASS_DARK;
`else
    localparam rgb_t C0 = DIRT_DARK, C1 = DIRT_MID, C2 = DIRT_LIGHT, C3 = DIRT_GRAY;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] tx = '0;
    logic [9:0] ty = '0;
    logic       tpv = 1'b0;
    logic       tfs [3] = '{1'b0, 1'b0, 1'b0};
    logic       tse [3] = '{1'b0, 1'b0, 1'b0};
    out_t       act [3];
    out_t       pend [3];
    int         m_off [3];
    int         m_cnt [3];
    int         step_c [3] = '{1, 600, 1};
    int         div_c [3] = '{2, 1, 1};
    int         passed = 0;
    int         total = 0;
    vec_t       tab [13];

    always #5 clk = ~clk;

    terrain_band_renderer_if if0 ();
    terrain_band_renderer_if if1 ();
    terrain_band_renderer_if if2 ();

    assign if0.x = tx; assign if0.y = ty; assign if0.pix_valid = tpv;
    assign if0.frame_start = tfs[0]; assign if0.scroll_en = tse[0];
    assign if1.x = tx; assign if1.y = ty; assign if1.pix_valid = tpv;
    assign if1.frame_start = tfs[1]; assign if1.scroll_en = tse[1];
    assign if2.x = tx; assign if2.y = ty; assign if2.pix_valid = tpv;
    assign if2.frame_start = tfs[2]; assign if2.scroll_en = tse[2];
    assign act[0] = {if0.out_valid, if0.enable, if0.color};
    assign act[1] = {if1.out_valid, if1.enable, if1.color};
    assign act[2] = {if2.out_valid, if2.enable, if2.color};

    terrain_band_renderer u_d0 (.clk(clk), .reset(reset), .bus(if0));
    terrain_band_renderer #(.SCROLL_STEP(600), .FRAME_DIV(1)) u_d1 (.clk(clk), .reset(reset), .bus(if1));
    terrain_band_renderer #(.SCROLL_STEP(1), .FRAME_DIV(1)) u_d2 (.clk(clk), .reset(reset), .bus(if2));

    // Reference: band rows 150..179, 2x2 cells, texture indexed by wrapped screen column
    function automatic out_t model(input logic [9:0] x, input logic [9:0] y, input logic pv, input int off);
        rgb_t shades [4];
        int   sx, cx, cy;
        out_t o;
        shades = '{DIRT_DARK, DIRT_MID, DIRT_LIGHT, DIRT_GRAY};
        o = {pv, 1'b0, BLACK};
        if (pv && y >= 150 && y < 180) begin
            sx = (int'(x) + off) % 640;
            cx = sx / 2;
            cy = (int'(y) - 150) / 2;
            o.en = 1'b1;
            o.col = shades[(cx + cy) % 4];
`ifdef TERRAIN_GRASS_TOP_EN
            if (cy == 0) o.col = (cx % 2 == 1) ? GRASS_DARK : GRASS_LIGHT;
`endif
        end
        return o;
    endfunction

    function automatic vec_t mk(input int x, input int y, input logic pv, input logic en, input rgb_t col);
        vec_t v;
        v.x = 10'(x);
        v.y = 10'(y);
        v.pv = pv;
        v.exp = {pv, en, col};
        return v;
    endfunction

    task automatic chk(input string nm, input out_t a, input out_t e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got ov=%b en=%b col=%h, want ov=%b en=%b col=%h",
                      nm, a.ov, a.en, a.col, e.ov, e.en, e.col);
    endtask

    // One clock: predict from current inputs, advance the scroll model, then check the pixel
    // predicted one call earlier (2-clock latency overall).
    task automatic cyc();
        out_t now [3];
        logic r;
        r = reset;
        for (int d = 0; d < 3; d++) begin
            now[d] = model(tx, ty, tpv, m_off[d]);
            if (r) begin
                m_off[d] = 0;
                m_cnt[d] = 0;
            end else if (tfs[d] && tse[d]) begin
                if (m_cnt[d] == div_c[d] - 1) begin
                    m_cnt[d] = 0;
                    m_off[d] = (m_off[d] + step_c[d]) % 640;
                end else m_cnt[d]++;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model d%0d", d), act[d], r ? out_t'('0) : pend[d]);
            pend[d] = r ? out_t'('0) : now[d];
        end
    endtask

    task automatic pix(input int x, input int y);
        tx = 10'(x); ty = 10'(y); tpv = 1'b1;
        cyc();
        tpv = 1'b0;
        cyc();
    endtask

    initial begin
        tab[0]  = mk(0,    149, 1'b1, 1'b0, BLACK);
        tab[1]  = mk(0,    150, 1'b1, 1'b1, C0);
        tab[2]  = mk(0,    179, 1'b1, 1'b1, DIRT_LIGHT);
        tab[3]  = mk(0,    180, 1'b1, 1'b0, BLACK);
        tab[4]  = mk(2,    150, 1'b1, 1'b1, C1);
        tab[5]  = mk(4,    150, 1'b1, 1'b1, C2);
        tab[6]  = mk(6,    150, 1'b1, 1'b1, C3);
        tab[7]  = mk(0,    150, 1'b0, 1'b0, BLACK);
        tab[8]  = mk(2,    152, 1'b1, 1'b1, DIRT_LIGHT);
        tab[9]  = mk(639,  160, 1'b1, 1'b1, DIRT_DARK);
        tab[10] = mk(1000, 160, 1'b1, 1'b1, DIRT_MID);
        tab[11] = mk(0,    479, 1'b1, 1'b0, BLACK);
        tab[12] = mk(7,    153, 1'b1, 1'b1, DIRT_DARK);

        reset = 1'b1;
        tx = 10'd0; ty = 10'd150; tpv = 1'b1;
        repeat (3) cyc();
        chk("reset d0", act[0], out_t'('0));
        reset = 1'b0;

        for (int i = 0; i <= 13; i++) begin
            if (i < 13) begin
                tx = tab[i].x; ty = tab[i].y; tpv = tab[i].pv;
            end else tpv = 1'b0;
            cyc();
            if (i > 0) chk($sformatf("table %0d", i - 1), act[0], tab[i - 1].exp);
        end

        tse[0] = 1'b1; tse[1] = 1'b1;
        for (int p = 0; p < 4; p++) begin
            tfs[0] = 1'b1; tfs[1] = (p < 2);
            cyc();
            tfs[0] = 1'b0; tfs[1] = 1'b0;
            cyc();
        end
        pix(0, 150);
        chk("scroll d0 off2", act[0], {1'b1, 1'b1, C1});
        pix(100, 150);
        chk("wrap d1 off560", act[1], {1'b1, 1'b1, C2});
        tse[0] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tfs[0] = 1'b1;
            cyc();
            tfs[0] = 1'b0;
            cyc();
        end
        pix(0, 150);
        chk("hold d0 off2", act[0], {1'b1, 1'b1, C1});

        tse[2] = 1'b1;
        tx = 10'd0; ty = 10'd150; tpv = 1'b1; tfs[2] = 1'b1;
        cyc();
        tfs[2] = 1'b0; tx = 10'd1;
        cyc();
        chk("coincident old off", act[2], {1'b1, 1'b1, C0});
        tpv = 1'b0;
        cyc();
        chk("coincident new off", act[2], {1'b1, 1'b1, C1});

        for (int n = 0; n < 3000; n++) begin
            reset = (n % 700) >= 697;
            tx = 10'($urandom_range(0, 639));
            ty = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 479)) : 10'($urandom_range(140, 190));
            tpv = $urandom_range(0, 3) != 0;
            for (int d = 0; d < 3; d++) begin
                tfs[d] = $urandom_range(0, 7) == 0;
                tse[d] = $urandom_range(0, 4) != 0;
            end
            cyc();
        end
        reset = 1'b0;
        tpv = 1'b0;
        for (int d = 0; d < 3; d++) tfs[d] = 1'b0;
        repeat (2) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
